// File: rtl/mcb_sched_pkg.sv
// Shared types and constants for the MCB burst scheduler.
package mcb_sched_pkg;

    // Scheduler states: wait for calibration, arbitrate, issue one command, settle.
    typedef enum logic [2:0] {
        StCalib,
        StArb,
        StIssueWr,
        StIssueRd,
        StGap
    } state_e;

    localparam logic [2:0] MCB_INSTR_WR = 3'b000;
    localparam logic [2:0] MCB_INSTR_RD = 3'b001;

    typedef logic [29:0] addr_t;

endpackage

// File: rtl/mcb_rd_credit.sv
// Read credit tracker: counts 64-bit words commanded but not yet popped from
// the MCB read FIFO and reports whether the USB output FIFO can absorb one
// more read burst of bl_i words (each 64-bit word becomes two 32-bit entries).
module mcb_rd_credit #(
    parameter int unsigned OUT_AW = 9
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              issue_i,
    input  logic [6:0]        bl_i,
    input  logic              rd_pop_i,
    input  logic [OUT_AW-1:0] out_fifo_count_i,
    output logic              room_o
);

    logic [15:0] pending_q, pending_d;
    logic [31:0] need;

    // Net the issue and the pop of the same cycle; pops of data commanded
    // before a reset are not credited, so the counter saturates at zero.
    always_comb begin
        pending_d = pending_q;
        if (issue_i) begin
            pending_d = pending_d + {9'b0, bl_i};
        end
        if (rd_pop_i && pending_d != 16'd0) begin
            pending_d = pending_d - 16'd1;
        end
    end

    // Outstanding-word register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pending_q <= 16'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign need = {{(32 - OUT_AW){1'b0}}, out_fifo_count_i}
                + {15'b0, pending_q, 1'b0}
                + {24'b0, bl_i, 1'b0};

    assign room_o = need < (32'd1 << OUT_AW);

endmodule

// File: rtl/mcb_burst_scheduler.sv
// Command scheduler for one Spartan-6 MCB user port. Interleaves full write
// bursts (data already staged in the MCB write FIFO) with read bursts sized
// to fit the USB output FIFO. All outputs are registered.
// Build option: define MCB_SCHED_RR_EN for round-robin arbitration when both
// streams are ready; otherwise writes have fixed priority.
module mcb_burst_scheduler
    import mcb_sched_pkg::*;
#(
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned OUT_AW    = 9
) (
    input  logic              c3_cmd_clk,
    input  logic              rst_n_i,
    input  logic              c3_calib_done,
    input  logic              c3_cmd_full,
    input  logic [6:0]        c3_wr_count,
    input  logic              c3_rd_pop,
    input  logic [OUT_AW-1:0] out_fifo_count,
    input  logic [29:0]       start_wr_addr_i,
    input  logic [29:0]       end_wr_addr_i,
    input  logic              new_wraddr_req,
    input  logic [29:0]       start_rd_addr_i,
    input  logic [29:0]       rd_len,
    input  logic              rd_start,
    output logic              c3_cmd_en,
    output logic [2:0]        c3_cmd_instr,
    output logic [5:0]        c3_cmd_bl,
    output logic [29:0]       c3_cmd_byte_addr,
    output logic [29:0]       wr_addr_o,
    output logic              wr_wrap,
    output logic              rd_busy,
    output logic              rd_done
);

    localparam logic [6:0] BurstBl = 7'(BURST_LEN);
    localparam addr_t      WrStep  = addr_t'(8 * BURST_LEN);

    state_e     state_q, state_d;
    logic       cmd_en_q, cmd_en_d;
    logic [2:0] cmd_instr_q, cmd_instr_d;
    logic [5:0] cmd_bl_q, cmd_bl_d;
    addr_t      cmd_addr_q, cmd_addr_d;
    addr_t      wr_addr_q, wr_addr_d;
    logic       wr_wrap_q, wr_wrap_d;
    logic       wr_reload_q, wr_reload_d;
    logic       rd_busy_q, rd_busy_d;
    logic       rd_done_q, rd_done_d;
    addr_t      rd_addr_q, rd_addr_d;
    addr_t      rd_remaining_q, rd_remaining_d;
`ifdef MCB_SCHED_RR_EN
    logic       last_rd_q, last_rd_d;
`endif

    addr_t      wr_next;
    logic [6:0] bl_next;
    logic       room;
    logic       wr_ready, rd_ready;
    logic       grant_wr, grant_rd;
    logic       rd_issue;

    assign wr_next = wr_addr_q + WrStep;
    assign bl_next = (rd_remaining_q < addr_t'(BURST_LEN)) ? rd_remaining_q[6:0] : BurstBl;

    assign wr_ready = (c3_wr_count >= BurstBl) && !c3_cmd_full;
    assign rd_ready = rd_busy_q && !c3_cmd_full && room;

    // Pick a requester; a lone ready requester always wins.
    always_comb begin
`ifdef MCB_SCHED_RR_EN
        grant_wr = wr_ready && (!rd_ready || last_rd_q);
`else
        grant_wr = wr_ready;
`endif
        grant_rd = rd_ready && !grant_wr;
    end

    assign rd_issue = (state_q == StArb) && grant_rd;

    mcb_rd_credit #(
        .OUT_AW (OUT_AW)
    ) u_rd_credit (
        .clk_i            (c3_cmd_clk),
        .rst_n_i          (rst_n_i),
        .issue_i          (rd_issue),
        .bl_i             (bl_next),
        .rd_pop_i         (c3_rd_pop),
        .out_fifo_count_i (out_fifo_count),
        .room_o           (room)
    );

    // Next-state and registered-output logic. Command fields and pointer
    // updates are computed on the ARB decision so that wr_wrap and rd_done
    // land in the same cycle as the command strobe.
    always_comb begin
        state_d        = state_q;
        cmd_en_d       = 1'b0;
        cmd_instr_d    = cmd_instr_q;
        cmd_bl_d       = cmd_bl_q;
        cmd_addr_d     = cmd_addr_q;
        wr_addr_d      = wr_addr_q;
        wr_wrap_d      = 1'b0;
        wr_reload_d    = wr_reload_q | new_wraddr_req;
        rd_busy_d      = rd_busy_q;
        rd_done_d      = 1'b0;
        rd_addr_d      = rd_addr_q;
        rd_remaining_d = rd_remaining_q;
`ifdef MCB_SCHED_RR_EN
        last_rd_d      = last_rd_q;
`endif

        unique case (state_q)
            StCalib: begin
                if (c3_calib_done) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (grant_wr) begin
                    state_d     = StIssueWr;
                    cmd_en_d    = 1'b1;
                    cmd_instr_d = MCB_INSTR_WR;
                    cmd_bl_d    = 6'(BURST_LEN - 1);
                    cmd_addr_d  = wr_addr_q;
                    if (wr_next > end_wr_addr_i) begin
                        wr_addr_d = start_wr_addr_i;
                        wr_wrap_d = 1'b1;
                    end else begin
                        wr_addr_d = wr_next;
                    end
`ifdef MCB_SCHED_RR_EN
                    last_rd_d = 1'b0;
`endif
                end else if (grant_rd) begin
                    state_d        = StIssueRd;
                    cmd_en_d       = 1'b1;
                    cmd_instr_d    = MCB_INSTR_RD;
                    cmd_bl_d       = 6'(bl_next - 7'd1);
                    cmd_addr_d     = rd_addr_q;
                    rd_addr_d      = rd_addr_q + {20'b0, bl_next, 3'b000};
                    rd_remaining_d = rd_remaining_q - {23'b0, bl_next};
                    if (rd_remaining_d == '0) begin
                        rd_done_d = 1'b1;
                        rd_busy_d = 1'b0;
                    end
`ifdef MCB_SCHED_RR_EN
                    last_rd_d = 1'b1;
`endif
                end
            end
            StIssueWr, StIssueRd: begin
                state_d = StGap;
            end
            StGap: begin
                state_d = StArb;
            end
            default: begin
                state_d = StCalib;
            end
        endcase

        // Pointer reload overrides any increment from a write granted now.
        if ((state_q == StArb || state_q == StGap) && wr_reload_d) begin
            wr_addr_d   = start_wr_addr_i;
            wr_wrap_d   = 1'b0;
            wr_reload_d = 1'b0;
        end

        // A new read is accepted only when idle; a zero-length read just
        // reports completion.
        if (rd_start && !rd_busy_q) begin
            if (rd_len == '0) begin
                rd_done_d = 1'b1;
            end else begin
                rd_busy_d      = 1'b1;
                rd_addr_d      = start_rd_addr_i;
                rd_remaining_d = rd_len;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge c3_cmd_clk) begin
        if (!rst_n_i) begin
            state_q        <= StCalib;
            cmd_en_q       <= 1'b0;
            cmd_instr_q    <= 3'b000;
            cmd_bl_q       <= 6'd0;
            cmd_addr_q     <= '0;
            wr_addr_q      <= '0;
            wr_wrap_q      <= 1'b0;
            wr_reload_q    <= 1'b0;
            rd_busy_q      <= 1'b0;
            rd_done_q      <= 1'b0;
            rd_addr_q      <= '0;
            rd_remaining_q <= '0;
`ifdef MCB_SCHED_RR_EN
            last_rd_q      <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            cmd_en_q       <= cmd_en_d;
            cmd_instr_q    <= cmd_instr_d;
            cmd_bl_q       <= cmd_bl_d;
            cmd_addr_q     <= cmd_addr_d;
            wr_addr_q      <= wr_addr_d;
            wr_wrap_q      <= wr_wrap_d;
            wr_reload_q    <= wr_reload_d;
            rd_busy_q      <= rd_busy_d;
            rd_done_q      <= rd_done_d;
            rd_addr_q      <= rd_addr_d;
            rd_remaining_q <= rd_remaining_d;
`ifdef MCB_SCHED_RR_EN
            last_rd_q      <= last_rd_d;
`endif
        end
    end

    assign c3_cmd_en        = cmd_en_q;
    assign c3_cmd_instr     = cmd_instr_q;
    assign c3_cmd_bl        = cmd_bl_q;
    assign c3_cmd_byte_addr = cmd_addr_q;
    assign wr_addr_o        = wr_addr_q;
    assign wr_wrap          = wr_wrap_q;
    assign rd_busy          = rd_busy_q;
    assign rd_done          = rd_done_q;

endmodule

// File: tb/tb_mcb_burst_scheduler.sv
// Scoreboard bench for mcb_burst_scheduler: stimulus pushes expected commands,
// a negedge monitor pops and compares every command strobe.
module tb_mcb_burst_scheduler;

    localparam int BL     = 32;
    localparam int OUT_AW = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              calib_done = 1'b0;
    logic              cmd_full = 1'b0;
    logic [6:0]        wr_count = 7'd0;
    logic              rd_pop = 1'b0;
    logic [OUT_AW-1:0] ofifo_count = '0;
    logic [29:0]       wr_start = '0;
    logic [29:0]       wr_end = '0;
    logic              wr_req = 1'b0;
    logic [29:0]       rd_addr_in = '0;
    logic [29:0]       rd_len_in = '0;
    logic              rd_go = 1'b0;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [29:0]       cmd_addr;
    logic [29:0]       wr_addr;
    logic              wrap;
    logic              busy;
    logic              done;

    mcb_burst_scheduler #(
        .BURST_LEN (BL),
        .OUT_AW    (OUT_AW)
    ) dut (
        .c3_cmd_clk       (clk),
        .rst_n_i          (rst_n),
        .c3_calib_done    (calib_done),
        .c3_cmd_full      (cmd_full),
        .c3_wr_count      (wr_count),
        .c3_rd_pop        (rd_pop),
        .out_fifo_count   (ofifo_count),
        .start_wr_addr_i  (wr_start),
        .end_wr_addr_i    (wr_end),
        .new_wraddr_req   (wr_req),
        .start_rd_addr_i  (rd_addr_in),
        .rd_len           (rd_len_in),
        .rd_start         (rd_go),
        .c3_cmd_en        (cmd_en),
        .c3_cmd_instr     (cmd_instr),
        .c3_cmd_bl        (cmd_bl),
        .c3_cmd_byte_addr (cmd_addr),
        .wr_addr_o        (wr_addr),
        .wr_wrap          (wrap),
        .rd_busy          (busy),
        .rd_done          (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
        logic        wrap;
        logic        done;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncmd = 0;

    // Reference model state (plain arithmetic on the documented rules).
    logic [29:0] m_wr_ptr = '0;
    logic [29:0] m_rd_addr = '0;
    int          m_rd_rem = 0;
    int          m_pending = 0;
    bit          m_last_rd = 1'b1;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    function automatic void push_wr();
        cmd_t        c;
        logic [29:0] nxt;
        nxt     = m_wr_ptr + 30'(8 * BL);
        c.instr = 3'b000;
        c.bl    = 6'(BL - 1);
        c.addr  = m_wr_ptr;
        c.wrap  = (nxt > wr_end);
        c.done  = 1'b0;
        m_wr_ptr  = c.wrap ? wr_start : nxt;
        m_last_rd = 1'b0;
        exp_q.push_back(c);
    endfunction

    function automatic void push_rd();
        cmd_t c;
        int   b;
        b       = (m_rd_rem < BL) ? m_rd_rem : BL;
        c.instr = 3'b001;
        c.bl    = 6'(b - 1);
        c.addr  = m_rd_addr;
        c.wrap  = 1'b0;
        c.done  = (m_rd_rem == b);
        m_rd_addr = m_rd_addr + 30'(8 * b);
        m_rd_rem  = m_rd_rem - b;
        m_pending = m_pending + b;
        m_last_rd = 1'b1;
        exp_q.push_back(c);
    endfunction

    // Monitor: every command strobe must match the head of the queue.
    always @(negedge clk) begin
        cmd_t got;
        cmd_t e;
        if (rst_n && cmd_en) begin
            ncmd++;
            got = {cmd_instr, cmd_bl, cmd_addr, wrap, done};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd got=%h exp=none", got);
            end else begin
                e = exp_q.pop_front();
                chk("cmd", 64'(got), 64'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=%0d_left exp=0_left", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reload(input logic [29:0] s, input logic [29:0] e);
        wr_start = s;
        wr_end   = e;
        wr_req   = 1'b1;
        @(negedge clk);
        wr_req   = 1'b0;
        m_wr_ptr = s;
        tick(2);
    endtask

    task automatic start_read(input logic [29:0] a, input int len);
        rd_addr_in = a;
        rd_len_in  = 30'(len);
        rd_go      = 1'b1;
        m_rd_addr  = a;
        m_rd_rem   = len;
        @(negedge clk);
        rd_go = 1'b0;
    endtask

    task automatic drain();
        while (m_pending > 0) begin
            rd_pop = 1'b1;
            @(negedge clk);
            m_pending--;
        end
        rd_pop = 1'b0;
        tick(2);
    endtask

    task automatic run_writes(input int n, input string name);
        for (int i = 0; i < n; i++) push_wr();
        wr_count = 7'd32;
        wait_empty(name);
        wr_count = 7'd0;
        tick(4);
        chk({name, "_ptr"}, 64'(wr_addr), 64'(m_wr_ptr));
    endtask

    task automatic run_read(input logic [29:0] a, input int len, input string name);
        start_read(a, len);
        chk({name, "_busy"}, 64'(busy), 64'(1));
        while (m_rd_rem > 0) push_rd();
        wait_empty(name);
        tick(2);
        chk({name, "_idle"}, 64'(busy), 64'(0));
        drain();
    endtask

    initial begin
        int n0;
        logic [29:0] s;
        // Reset values.
        tick(3);
        chk("rst_cmd_en", 64'(cmd_en), 64'(0));
        chk("rst_fields", 64'({cmd_instr, cmd_bl, cmd_addr}), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_flags", 64'({wrap, busy, done}), 64'(0));
        wr_start = 30'h0;
        wr_end   = 30'h100;
        rst_n    = 1'b1;

        // Calibration hold, then first write at the reset pointer.
        wr_count = 7'd40;
        tick(20);
        chk("calib_hold", 64'(ncmd), 64'(0));
        push_wr();
        calib_done = 1'b1;
        wait_empty("calib_release");
        wr_count = 7'd0;
        tick(4);

        // Ring wrap: 0x0, 0x100 (wrap), 0x0.
        reload(30'h0, 30'h100);
        run_writes(3, "wrap");

        // Randomized rings, plus one ring at the top of the address space.
        for (int r = 0; r < 3; r++) begin
            s = 30'($urandom_range(0, 32'h1FFF_FFFF)) & ~30'h7;
            reload(s, s + 30'(256 * $urandom_range(1, 4)) + (30'($urandom_range(0, 255)) & ~30'h7));
            run_writes($urandom_range(2, 6), "rand_wr");
        end
        reload(30'h3FFF_FF00, 30'h3FFF_FFFF);
        run_writes(2, "top_wr");

        // Short final burst, then randomized reads.
        run_read(30'h2000, 70, "rd70");
        for (int r = 0; r < 4; r++) begin
            run_read(30'($urandom_range(0, 32'h3FFF_0000)) & ~30'h7, $urandom_range(1, 150),
                     "rand_rd");
        end

        // Zero-length read: done pulse only.
        start_read(30'h3000, 0);
        chk("len0_done", 64'({done, busy}), 64'(2'b10));
        tick(1);
        chk("len0_clear", 64'(done), 64'(0));

        // Output FIFO backpressure boundary: 448 blocks, 447 admits.
        ofifo_count = 9'd448;
        n0 = ncmd;
        start_read(30'h4000, 32);
        tick(20);
        chk("bp_blocked", 64'(ncmd), 64'(n0));
        chk("bp_busy", 64'(busy), 64'(1));
        repeat (16) begin
            rd_pop = 1'b1;
            @(negedge clk);
        end
        rd_pop = 1'b0;
        push_rd();
        ofifo_count = 9'd447;
        wait_empty("bp_release");
        ofifo_count = 9'd0;
        tick(2);
        drain();

        // Both requesters ready for four grants.
        reload(30'h10000, 30'h20000);
        ofifo_count = 9'd500;
        start_read(30'h8000, 128);
        tick(5);
        for (int i = 0; i < 4; i++) begin
`ifdef MCB_SCHED_RR_EN
            if (m_last_rd) push_wr();
            else push_rd();
`else
            push_wr();
`endif
        end
        wr_count    = 7'd32;
        ofifo_count = 9'd0;
        wait_empty("both_ready");
        wr_count = 7'd0;
        while (m_rd_rem > 0) push_rd();
        wait_empty("both_tail");
        tick(4);
        chk("both_ptr", 64'(wr_addr), 64'(m_wr_ptr));
        drain();

        // Reset in the middle of a read held off by the output FIFO.
        ofifo_count = 9'd400;
        start_read(30'hA000, 200);
        push_rd();
        wait_empty("mid_rd");
        tick(3);
        chk("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_cmd", 64'({cmd_en, cmd_instr, cmd_bl, cmd_addr}), 64'(0));
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("mid_rst_flags", 64'({wrap, busy, done}), 64'(0));
        rst_n     = 1'b1;
        m_pending = 0;
        m_rd_rem  = 0;
        m_wr_ptr  = '0;
        m_last_rd = 1'b1;
        tick(2);

        // Outstanding credit cleared: a read at 400 fits again.
        run_read(30'hB000, 32, "post_rst_rd");
        ofifo_count = 9'd0;
        run_writes(1, "post_rst_wr");
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
